// File: rtl/bfp_denormalizer_if.sv
// Stream bundle for the BFP denormalizer: normalized mantissas in, denormalized samples out.
interface bfp_denormalizer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned EXP_W = $clog2(WIDTH + 1)
);
    logic [WIDTH-1:0] i_I;
    logic [WIDTH-1:0] i_Q;
    logic [EXP_W-1:0] i_exponent;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_I;
    logic [WIDTH-1:0] o_Q;
    logic             o_valid;
    logic             i_ready;
    logic             o_last;
    logic             o_exp_err;

    modport master (
        output i_I, i_Q, i_exponent, i_valid, i_ready,
        input  o_ready, o_I, o_Q, o_valid, o_last, o_exp_err
    );

    modport slave (
        input  i_I, i_Q, i_exponent, i_valid, i_ready,
        output o_ready, o_I, o_Q, o_valid, o_last, o_exp_err
    );
endinterface

// File: rtl/bfp_denormalizer.sv
// Block-floating-point decoder: right-shifts I/Q by a per-block latched exponent,
// with block framing, exponent-consistency flag and regenerated end-of-block marker.
module bfp_denormalizer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned BLOCK_SIZE = 256,
    parameter bit          IS_SIGNED  = 1'b1,
    parameter bit          ROUND      = 1'b1,
    parameter int unsigned EXP_W      = $clog2(WIDTH + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    bfp_denormalizer_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(BLOCK_SIZE + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BLOCK_SIZE - 1);
    localparam logic [EXP_W-1:0] ExpMax = EXP_W'(WIDTH);

    typedef enum logic {StIdle, StInBlock} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] i_q, i_d, q_q, q_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             ready;
    logic             accept;
    logic [EXP_W-1:0] shift_exp;
    logic [EXP_W-1:0] shift;

    // Round-half-up adds the most significant discarded bit; cannot overflow for s >= 1.
    function automatic logic [WIDTH-1:0] denorm(input logic [WIDTH-1:0] x,
                                                input logic [EXP_W-1:0] s);
        logic [WIDTH-1:0] sh;
        logic [WIDTH-1:0] tmp;
        logic             rb;
        if (IS_SIGNED) sh = $signed(x) >>> s;
        else           sh = x >> s;
        rb = 1'b0;
        if (ROUND && (s != '0)) begin
            tmp = x >> (s - 1'b1);
            rb  = tmp[0];
        end
        return sh + {{(WIDTH-1){1'b0}}, rb};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        i_d     = i_q;
        q_d     = q_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;

        ready     = !valid_q || bus.i_ready;
        accept    = bus.i_valid && ready;
        shift_exp = (state_q == StIdle) ? bus.i_exponent : exp_q;
        shift     = (shift_exp > ExpMax) ? ExpMax : shift_exp;

        if (accept) begin
            valid_d = 1'b1;
            i_d     = denorm(bus.i_I, shift);
            q_d     = denorm(bus.i_Q, shift);
            last_d  = 1'b0;
            err_d   = 1'b0;
            if (state_q == StIdle) begin
                exp_d   = bus.i_exponent;
                cnt_d   = CntW'(1);
                state_d = StInBlock;
            end else begin
                err_d = (bus.i_exponent != exp_q);
                if (cnt_q == CntLast) begin
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (bus.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            exp_q   <= '0;
            i_q     <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            i_q     <= i_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_I       = i_q;
    assign bus.o_Q       = q_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_last    = last_q;
    assign bus.o_exp_err = err_q;
endmodule

// File: tb/tb_bfp_denormalizer.sv
// Directed bench: three shared-stimulus instances (signed/round, signed/trunc, unsigned/round).
module tb_bfp_denormalizer;
    logic clk;
    logic rst_n;
    logic [15:0] d_I, d_Q;
    logic [4:0]  d_exp;
    logic        d_valid, d_ready;
    int total = 0;
    int bad   = 0;

    bfp_denormalizer_if #(.WIDTH(16), .EXP_W(5)) ifa ();
    bfp_denormalizer_if #(.WIDTH(16), .EXP_W(5)) ifb ();
    bfp_denormalizer_if #(.WIDTH(16), .EXP_W(5)) ifc ();

    assign ifa.i_I = d_I;  assign ifa.i_Q = d_Q;  assign ifa.i_exponent = d_exp;
    assign ifa.i_valid = d_valid;  assign ifa.i_ready = d_ready;
    assign ifb.i_I = d_I;  assign ifb.i_Q = d_Q;  assign ifb.i_exponent = d_exp;
    assign ifb.i_valid = d_valid;  assign ifb.i_ready = d_ready;
    assign ifc.i_I = d_I;  assign ifc.i_Q = d_Q;  assign ifc.i_exponent = d_exp;
    assign ifc.i_valid = d_valid;  assign ifc.i_ready = d_ready;

    bfp_denormalizer #(.WIDTH(16), .BLOCK_SIZE(256), .IS_SIGNED(1'b1), .ROUND(1'b1), .EXP_W(5))
        u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    bfp_denormalizer #(.WIDTH(16), .BLOCK_SIZE(256), .IS_SIGNED(1'b1), .ROUND(1'b0), .EXP_W(5))
        u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));
    bfp_denormalizer #(.WIDTH(16), .BLOCK_SIZE(256), .IS_SIGNED(1'b0), .ROUND(1'b1), .EXP_W(5))
        u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one sample with downstream ready, then sample outputs just after the edge.
    task automatic drive(input logic [15:0] i_val, input logic [15:0] q_val,
                         input logic [4:0] e);
        d_I = i_val;  d_Q = q_val;  d_exp = e;  d_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k_in, k_out, cyc;
        rst_n = 1'b0;  d_valid = 1'b0;  d_ready = 1'b1;
        d_I = '0;  d_Q = '0;  d_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 16'(ifa.o_valid), 16'h0);
        chk("rst_I", ifa.o_I, 16'h0);
        chk("rst_Q", ifa.o_Q, 16'h0);
        chk("rst_last", 16'(ifa.o_last), 16'h0);
        chk("rst_err", 16'(ifa.o_exp_err), 16'h0);
        chk("rst_ready", 16'(ifa.o_ready), 16'h1);
        rst_n = 1'b1;

        // Block 1: exponent 3, full block, latency and o_last position.
        for (int n = 0; n < 256; n++) begin
            d_I = 16'h4000;  d_Q = 16'hC000;  d_exp = 5'd3;  d_valid = 1'b1;
            if (n == 0) chk("lat_pre_valid", 16'(ifa.o_valid), 16'h0);
            drive(16'h4000, 16'hC000, 5'd3);
            chk("b1_aI", ifa.o_I, 16'h0800);
            chk("b1_aQ", ifa.o_Q, 16'hF800);
            chk("b1_bI", ifb.o_I, 16'h0800);
            chk("b1_bQ", ifb.o_Q, 16'hF800);
            chk("b1_cQ", ifc.o_Q, 16'h1800);
            chk("b1_valid", 16'(ifa.o_valid), 16'h1);
            chk("b1_last", 16'(ifa.o_last), 16'(n == 255));
            chk("b1_err", 16'(ifa.o_exp_err), 16'h0);
        end

        // Block 2: exponent 2 rounding vs truncation.
        drive(16'h0006, 16'h0006, 5'd2);
        chk("r6_aI", ifa.o_I, 16'h0002);  chk("r6_bI", ifb.o_I, 16'h0001);
        chk("r6_cI", ifc.o_I, 16'h0002);
        drive(16'hFFFA, 16'hFFFA, 5'd2);
        chk("rm6_aI", ifa.o_I, 16'hFFFF);  chk("rm6_aQ", ifa.o_Q, 16'hFFFF);
        chk("rm6_bI", ifb.o_I, 16'hFFFE);  chk("rm6_cI", ifc.o_I, 16'h3FFF);
        drive(16'h7FFF, 16'h7FFF, 5'd2);
        chk("rmax_aI", ifa.o_I, 16'h2000);  chk("rmax_bI", ifb.o_I, 16'h1FFF);
        chk("rmax_cI", ifc.o_I, 16'h2000);
        for (int n = 3; n < 256; n++) begin
            drive(16'h0000, 16'h0000, 5'd2);
            chk("b2_last", 16'(ifa.o_last), 16'(n == 255));
        end

        // Block 3: exponent 20 clamps to 16.
        drive(16'h8000, 16'h7FFF, 5'd20);
        chk("cl_aI", ifa.o_I, 16'h0000);  chk("cl_bI", ifb.o_I, 16'hFFFF);
        chk("cl_cI", ifc.o_I, 16'h0001);  chk("cl_aQ", ifa.o_Q, 16'h0000);
        chk("cl_bQ", ifb.o_Q, 16'h0000);
        for (int n = 1; n < 256; n++) begin
            drive(16'h0000, 16'h0000, 5'd20);
            chk("b3_last", 16'(ifa.o_last), 16'(n == 255));
        end
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid", 16'(ifa.o_valid), 16'h0);

        // Block 4: latched exponent 4, mismatch on samples 10..19.
        for (int n = 0; n < 256; n++) begin
            drive(16'h0100, 16'h0100, ((n >= 10) && (n < 20)) ? 5'd5 : 5'd4);
            chk("b4_aI", ifa.o_I, 16'h0010);
            chk("b4_err", 16'(ifa.o_exp_err), 16'((n >= 10) && (n < 20)));
            chk("b4_last", 16'(ifa.o_last), 16'(n == 255));
        end

        // Block 5: new exponent 5 latched, reset after 100 samples.
        for (int n = 0; n < 100; n++) begin
            drive(16'h0100, 16'h0100, 5'd5);
            chk("b5_aI", ifa.o_I, 16'h0008);
            chk("b5_err", 16'(ifa.o_exp_err), 16'h0);
            chk("b5_last", 16'(ifa.o_last), 16'h0);
        end
        rst_n = 1'b0;  d_valid = 1'b0;
        #1;
        chk("mrst_valid", 16'(ifa.o_valid), 16'h0);
        chk("mrst_I", ifa.o_I, 16'h0);
        chk("mrst_Q", ifb.o_Q, 16'h0);
        chk("mrst_last", 16'(ifa.o_last), 16'h0);
        chk("mrst_err", 16'(ifa.o_exp_err), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Block 6: after reset, exponent 1 latched afresh, last after 256 samples.
        for (int n = 0; n < 256; n++) begin
            drive(16'h0100, 16'h0100, 5'd1);
            chk("b6_aI", ifa.o_I, 16'h0080);
            chk("b6_last", 16'(ifa.o_last), 16'(n == 255));
            chk("b6_err", 16'(ifa.o_exp_err), 16'h0);
        end
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b6_drain", 16'(ifa.o_valid), 16'h0);

        // Blocks 7-8: random downstream stalls, exponent 0 passes sequence numbers through.
        k_in = 0;  k_out = 0;  cyc = 0;
        d_exp = 5'd0;
        while ((k_out < 512) && (cyc < 5000)) begin
            d_valid = (k_in < 512);
            d_I = 16'(k_in);
            d_Q = ~16'(k_in);
            d_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ifa.o_valid) begin
                chk("st_I", ifa.o_I, 16'(k_out));
                chk("st_Q", ifa.o_Q, ~16'(k_out));
                chk("st_cI", ifc.o_I, 16'(k_out));
                chk("st_last", 16'(ifa.o_last), 16'((k_out == 255) || (k_out == 511)));
                chk("st_err", 16'(ifa.o_exp_err), 16'h0);
                if (d_ready) k_out++;
            end
            if (d_valid && ifa.o_ready) k_in++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("st_count", 16'(k_out), 16'(512));
        chk("st_sent", 16'(k_in), 16'(512));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bfp_denormalizer.md
Name: bfp_denormalizer

Overview:
Block-floating-point decoder: reverses block normalization by arithmetic right-shifting each I/Q mantissa by its block exponent, restoring the original scale. Sits downstream of the BFP normalizer/transport path, before fixed-point consumers such as DAC feed or a demodulator. Tracks block framing, latches one exponent per block, flags exponent inconsistency, and regenerates the end-of-block marker. Single-stage registered pipeline with valid/ready backpressure.

Parameters:
WIDTH, 16, mantissa and output sample width per rail
BLOCK_SIZE, 256, samples per block (>=2)
IS_SIGNED, 1, 1 = two's-complement with arithmetic shift; 0 = unsigned with logical shift
ROUND, 1, 1 = round-half-up on shifted-out bits; 0 = truncate
EXP_W, $clog2(WIDTH+1), exponent width (5 for WIDTH=16)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_I  in  WIDTH  normalized in-phase mantissa
i_Q  in  WIDTH  normalized quadrature mantissa
i_exponent  in  EXP_W  block exponent accompanying each sample
i_valid  in  1  input sample valid
o_ready  out  1  block accepts input this cycle
o_I  out  WIDTH  denormalized in-phase sample
o_Q  out  WIDTH  denormalized quadrature sample
o_valid  out  1  output sample valid
i_ready  in  1  downstream accepts output
o_last  out  1  qualifies final sample of block (valid with o_valid)
o_exp_err  out  1  qualifies sample whose i_exponent differed from latched block exponent

Behaviour:
- Clock i_clk; reset i_rst_n asynchronous active-low. Reset: o_I=0, o_Q=0, o_valid=0, o_last=0, o_exp_err=0, sample counter=0, latched exponent=0, state=IDLE.
- Accept = i_valid && o_ready. o_ready = !o_valid || i_ready (combinational). Output registers load only on accept; hold stable while o_valid && !i_ready. If no accept and i_ready, o_valid clears.
- Latency: 1 cycle, accept to o_valid. Full throughput with i_ready held high.
- States: IDLE (awaiting first sample of block), IN_BLOCK.
  - IDLE + accept: latch i_exponent, shift this sample by i_exponent, counter=1, o_exp_err=0, go IN_BLOCK.
  - IN_BLOCK + accept: shift by latched exponent (never i_exponent); o_exp_err=1 if i_exponent != latched value, else 0; counter+1.
  - Accepted sample with counter reaching BLOCK_SIZE: o_last=1 on that output, counter=0, go IDLE. Next accepted sample starts a new block with a new exponent.
- Effective shift s = min(exponent, WIDTH); exponents above WIDTH clamp to WIDTH.
- Shift: IS_SIGNED=1 arithmetic (sign fill); IS_SIGNED=0 logical (zero fill). s=0 passes data unchanged.
- Rounding (ROUND=1, s>0): result = shifted + bit[s-1] of input, in WIDTH bits. No overflow possible for s>=1. At s=WIDTH: signed negative input gives -1+1=0, non-negative gives 0 or +1 per MSB rule (MSB=0 gives 0); unsigned with MSB=1 gives 1.
- ROUND=0: pure truncation.
- I and Q always use the same shift.
- Reset mid-block: state returns to IDLE; the next accepted sample after release is treated as a block start.
- Backpressure mid-block does not affect counter or state; only accepts advance them.

Test Plan:
- Signed, ROUND=0, exponent 3 for 256 samples: i_I=0x4000 -> o_I=0x0800; i_Q=0xC000 -> o_Q=0xF800; o_last=1 only on 256th output; latency 1 cycle.
- ROUND=1, exponent 2: i_I=0x0006 -> 0x0002; i_I=0xFFFA (-6) -> 0xFFFF (-1); i_I=0x7FFF -> 0x2000.
- Exponent 20 with WIDTH=16 (clamp to 16): signed 0x8000 -> 0x0000 (ROUND=1) or 0xFFFF (ROUND=0); unsigned IS_SIGNED=0, 0x8000, ROUND=1 -> 0x0001.
- Block exponent 4, i_exponent changes to 5 at sample 10: samples still shifted by 4; o_exp_err=1 only on sample 10 onward while mismatch persists; next block latches 5 and error clears.
- Random i_ready toggling across 2 blocks: no sample lost or duplicated; outputs stable while stalled; o_last exactly on samples 256 and 512.
- Assert i_rst_n low at sample 100: all outputs 0 immediately; after release, the first sample latches a new exponent and o_last appears 256 samples later.
